serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Multi-cycle parametrised adder. Adds two WIDTH-bit operands plus a carry-in, processing SLICE bits per clock, from the LSB slice up to the MSB slice.
- A single carry register links the slices.
- Trades latency for area against a full-width ripple adder. Used by datapaths that cannot afford WIDTH full-adder cells.
- Start/busy/done handshake. Reports sum, carry-out and signed overflow.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 2.
- SLICE, 1, bits added per clock; 1 ≤ SLICE ≤ WIDTH; WIDTH mod SLICE must be 0.
- NSLICE, WIDTH/SLICE, derived localparam: number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; accepted only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in; sampled on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; sum/cout/overflow are valid in that cycle.
- sum  output  WIDTH  result register.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: one clk edge with rst_n=0 forces state=IDLE, and busy, done, sum, cout, overflow, carry register, slice counter and operand registers all to 0. Reset has priority over every other input.
- Reset mid-RUN aborts the operation: no done pulse, sum reads 0.
- IDLE: busy=0, done=0, outputs hold their previous values.
- start=1 at edge T in IDLE loads a, b, cin into internal registers, clears sum, sets count=0, and moves to RUN.
- RUN (edges T+1 .. T+NSLICE): each edge adds slice[count] of A and B plus the carry register through SLICE chained full-adder cells.
  - Writes the SLICE result bits into sum[count*SLICE +: SLICE].
  - Updates the carry register; count increments.
- On the edge where count=NSLICE-1:
  - cout takes the final carry.
  - overflow takes the carry into bit WIDTH-1 XOR the final carry; for SLICE=1 the carry into the MSB is the carry register's value before that edge.
  - State moves to DONE.
- DONE: done=1 and busy=0 for exactly one cycle.
  - First done-high cycle follows the accepting edge by NSLICE+1 cycles.
  - Next edge: if start=1, behave as an IDLE accept (back-to-back; done falls, busy rises). Otherwise go to IDLE.
- start during RUN is ignored; operand changes during RUN have no effect.
- sum, cout and overflow hold stable from DONE until the next accept.
- Arithmetic is modulo 2^WIDTH.
- {cout,sum} always equals a+b+cin of the accepted operands.
- Encoding: 2-bit state; count is clog2(NSLICE) bits, minimum 1.

Decomposition:
- Shared header (serial_adder_defs.vh) holds the state localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2. It is included by the RTL and the bench.
- One sub-module, ripple_slice (parameter SLICE): a combinational SLICE-bit ripple chain built from the team's full_adder cell.
  - Outputs: slice sum, carry-out, and carry into its top bit (for overflow).
- serial_adder holds the FSM, counter, operand and carry registers.

Test Plan:
- WIDTH=8, SLICE=1: a=0x5A, b=0x33, cin=0, start one cycle -> busy high 8 cycles; done at cycle 9 after accept; sum=0x8D, cout=0, overflow=1.
- WIDTH=8, SLICE=1: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, overflow=1.
- WIDTH=8, SLICE=4: a=0xFF, b=0xFF, cin=1 -> done 3 cycles after accept; sum=0xFF, cout=1, overflow=0. Exhaustive 4-bit sweep at WIDTH=4, SLICE=2 matches a+b+cin for all 512 cases.
- Start in the RUN cycle 2 with different operands -> ignored; first result unchanged. Start asserted in the DONE cycle with a=0x01, b=0x02 -> busy rises next cycle; second done gives sum=0x03.
- rst_n=0 for one edge at RUN cycle 3 -> next cycle busy=0, done=0, sum=0x00, cout=0. No done pulse for 20 cycles unless start is reasserted.
- Operands toggled every cycle during RUN -> result equals the operands sampled at accept.

Source files
------------

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_pkg
// Desc    : Shared state encoding and sizing helper for the serial adder.
// Rev     : 1.0
// ============================================================================
package serial_adder_pkg;
`include "serial_adder_defs.vh"

    // A single-slice configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module  : full_adder
// Desc    : One-bit full-adder cell.
// Rev     : 1.0
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule
`default_nettype wire

// File: rtl/serial_adder_defs.vh
`default_nettype none
// ============================================================================
// File    : serial_adder_defs.vh
// Desc    : State encoding shared by the serial adder RTL and its bench.
// Rev     : 1.0
// ============================================================================
localparam logic [1:0] IDLE = 2'd0;
localparam logic [1:0] RUN  = 2'd1;
localparam logic [1:0] DONE = 2'd2;
`default_nettype wire

// File: rtl/serial_adder_ripple_slice.sv
`default_nettype none
// ============================================================================
// Module  : ripple_slice
// Desc    : Combinational SLICE-bit ripple chain of full-adder cells.
// Rev     : 1.0
// ============================================================================
module ripple_slice #(
    parameter int SLICE = 1
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             cmsb
);
    logic [SLICE:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar i = 0; i < SLICE; i++) begin : g_bit
            full_adder u_fa (
                .a  (a[i]),
                .b  (b[i]),
                .ci (w_c[i]),
                .s  (s[i]),
                .co (w_c[i+1])
            );
        end
    endgenerate

    assign cout = w_c[SLICE];
    // Carry into the top bit of the slice, needed for signed overflow.
    assign cmsb = w_c[SLICE-1];
endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder
// Desc    : Multi-cycle adder, SLICE bits per clock, start/busy/done handshake.
// Rev     : 1.0
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int            NSLICE     = WIDTH / SLICE;
    localparam int            CW         = cnt_width(NSLICE);
    localparam logic [CW-1:0] C_LAST_CNT = CW'(NSLICE - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic [SLICE-1:0] w_s;
    logic             w_co;
    logic             w_cm;

    // Operand registers shift down each cycle, so the active slice is always the low bits.
    ripple_slice #(.SLICE(SLICE)) u_slice (
        .a    (r_a[SLICE-1:0]),
        .b    (r_b[SLICE-1:0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_co),
        .cmsb (w_cm)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_sum   <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (r_count == CW'(i)) r_sum[i*SLICE +: SLICE] <= w_s;
                    end
                    r_a     <= r_a >> SLICE;
                    r_b     <= r_b >> SLICE;
                    r_carry <= w_co;
                    r_count <= r_count + CW'(1);
                    if (r_count == C_LAST_CNT) begin
                        r_cout  <= w_co;
                        r_ovf   <= w_cm ^ w_co;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_adder
// Desc    : Bench for serial_adder at (8,1), (8,4) and (4,2) against an integer model.
// Rev     : 1.0
// ============================================================================
module tb_serial_adder;
`include "serial_adder_defs.vh"

    logic       clk = 1'b0;
    logic       rst_n;
    logic       st [3];
    logic [7:0] av [3];
    logic [7:0] bv [3];
    logic       ci [3];

    logic       busy81, done81, cout81, ovf81;
    logic [7:0] sum81;
    logic       busy84, done84, cout84, ovf84;
    logic [7:0] sum84;
    logic       busy42, done42, cout42, ovf42;
    logic [3:0] sum42;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .SLICE(1)) u_dut81 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0]), .b(bv[0]), .cin(ci[0]),
        .busy(busy81), .done(done81), .sum(sum81), .cout(cout81), .overflow(ovf81));
    serial_adder #(.WIDTH(8), .SLICE(4)) u_dut84 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1]), .b(bv[1]), .cin(ci[1]),
        .busy(busy84), .done(done84), .sum(sum84), .cout(cout84), .overflow(ovf84));
    serial_adder #(.WIDTH(4), .SLICE(2)) u_dut42 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2][3:0]), .b(bv[2][3:0]), .cin(ci[2]),
        .busy(busy42), .done(done42), .sum(sum42), .cout(cout42), .overflow(ovf42));

    function automatic int wid(input int w);
        return (w == 2) ? 4 : 8;
    endfunction

    function automatic int nsl(input int w);
        return (w == 0) ? 8 : 2;
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            0:       return busy81;
            1:       return busy84;
            default: return busy42;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            0:       return done81;
            1:       return done84;
            default: return done42;
        endcase
    endfunction

    function automatic logic [1:0] get_flags(input int w);
        return {get_busy(w), get_done(w)};
    endfunction

    function automatic logic [1:0] exp_flags(input logic [1:0] ph);
        return {ph == RUN, ph == DONE};
    endfunction

    // {overflow, cout, sum} with sum zero-extended to 8 bits
    function automatic logic [9:0] get_res(input int w);
        case (w)
            0:       return {ovf81, cout81, sum81};
            1:       return {ovf84, cout84, sum84};
            default: return {ovf42, cout42, 4'h0, sum42};
        endcase
    endfunction

    // Reference: unsigned sum for sum/cout, signed sum range test for overflow.
    function automatic logic [9:0] model(input int w, input logic [7:0] x, input logic [7:0] y,
                                         input logic c);
        int m, ux, uy, full, sx, sy, rs;
        logic [7:0] s8;
        logic       ov;
        m    = 1 << wid(w);
        ux   = int'(x) % m;
        uy   = int'(y) % m;
        full = ux + uy + int'(c);
        sx   = (ux >= m / 2) ? ux - m : ux;
        sy   = (uy >= m / 2) ? uy - m : uy;
        rs   = sx + sy + int'(c);
        ov   = (rs >= m / 2) || (rs < -(m / 2));
        s8   = 8'(full % m);
        return {ov, full >= m, s8};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input int w, input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                          input bit toggle, input bit poke, input bit hold);
        logic [9:0] e;
        int cyc;
        int bc;
        e     = model(w, ta, tbv, tc);
        st[w] = 1'b1;
        av[w] = ta;
        bv[w] = tbv;
        ci[w] = tc;
        @(posedge clk); #1;
        st[w] = 1'b0;
        check("accept_flags", 32'(get_flags(w)), 32'(exp_flags(RUN)));
        cyc = 1;
        bc  = 0;
        while (!get_done(w) && cyc < 40) begin
            if (get_busy(w)) bc++;
            st[w] = poke && (cyc == 2);
            if (toggle || st[w]) begin
                av[w] = 8'($urandom);
                bv[w] = 8'($urandom);
                ci[w] = 1'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        st[w] = 1'b0;
        check("latency", 32'(cyc), 32'(nsl(w) + 1));
        check("busy_cycles", 32'(bc), 32'(nsl(w)));
        check("done_flags", 32'(get_flags(w)), 32'(exp_flags(DONE)));
        check("result", 32'(get_res(w)), 32'(e));
        if (hold) begin
            @(posedge clk); #1;
            check("idle_flags", 32'(get_flags(w)), 32'(exp_flags(IDLE)));
            check("hold_result", 32'(get_res(w)), 32'(e));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            av[i] = 8'h00;
            bv[i] = 8'h00;
            ci[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) begin
            check("reset_flags", 32'(get_flags(w)), 32'(exp_flags(IDLE)));
            check("reset_result", 32'(get_res(w)), 32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op(0, 8'h5A, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(0, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op(1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);

        // Exhaustive sweep on the 4-bit instance
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++)
                    run_op(2, 8'(x), 8'(y), 1'(c), 1'b0, 1'b0, 1'b1);

        // Start during RUN ignored, then back-to-back start in the DONE cycle
        run_op(0, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in RUN cycle 3 after a result with cout=1
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        st[0] = 1'b1;
        av[0] = 8'hFF;
        bv[0] = 8'h00;
        ci[0] = 1'b0;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrun_rst_flags", 32'(get_flags(0)), 32'(exp_flags(IDLE)));
        check("midrun_rst_result", 32'(get_res(0)), 32'h0);
        dc = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (get_done(0)) dc++;
        end
        check("no_done_after_rst", 32'(dc), 32'h0);

        // Operands toggled during RUN, plus random traffic on all instances
        for (int i = 0; i < 12; i++)
            run_op(i % 2, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++)
            run_op(i % 3, 8'($urandom), 8'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
